// File: rtl/keccak_pkg.sv
// Shared Keccak definitions: lane count, default lane width, state shape and
// the sequencer FSM states.
package keccak_pkg;

    localparam int LANES     = 5;
    localparam int W_DEFAULT = 64;

    typedef logic [LANES-1:0][LANES-1:0][W_DEFAULT-1:0] state_t;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } fsm_t;

endpackage

// File: rtl/keccak_chi_plane.sv
// Combinational chi step over one plane: five lanes of a fixed j.
module keccak_chi_plane
    import keccak_pkg::*;
#(
    parameter int W = W_DEFAULT
) (
    input  logic [LANES-1:0][W-1:0] a,
    output logic [LANES-1:0][W-1:0] b
);

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        assign b[i] = a[i] ^ (~a[(i + 1) % LANES] & a[(i + 2) % LANES]);
    end

endmodule

// File: rtl/keccak_chi_seq.sv
// Sequential chi: loads a 5x5 state, transforms PPC planes per cycle in place,
// then holds the result until the consumer takes it.
module keccak_chi_seq
    import keccak_pkg::*;
#(
    parameter int W   = W_DEFAULT,
    parameter int PPC = 1
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic                              mode,
    input  logic [LANES-1:0][LANES-1:0][W-1:0] A,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [LANES-1:0][LANES-1:0][W-1:0] Ab,
    output logic                              busy
);

    typedef logic [LANES-1:0][LANES-1:0][W-1:0] st_t;

    fsm_t       fsm, fsm_n;
    logic [2:0] cnt, cnt_n;
    logic       mode_q, mode_n;
    st_t        st, st_n;

    logic [PPC-1:0][2:0]            pidx;
    logic [PPC-1:0][LANES-1:0][W-1:0] pin;
    logic [PPC-1:0][LANES-1:0][W-1:0] pout;

    // With all five planes per cycle the plane index is fixed, so the counter
    // never participates in addressing and cannot run past plane 4.
    for (genvar k = 0; k < PPC; k++) begin : g_plane
        if (PPC == LANES) begin : g_par
            assign pidx[k] = 3'(k);
        end else begin : g_ser
            assign pidx[k] = cnt + 3'(k);
        end

        for (genvar i = 0; i < LANES; i++) begin : g_in
            assign pin[k][i] = st[i][pidx[k]];
        end

        keccak_chi_plane #(.W(W)) u_plane (
            .a(pin[k]),
            .b(pout[k])
        );
    end

    always_comb begin
        fsm_n  = fsm;
        cnt_n  = cnt;
        mode_n = mode_q;
        st_n   = st;
        unique case (fsm)
            IDLE: begin
                if (in_valid) begin
                    st_n   = A;
                    mode_n = mode;
                    cnt_n  = '0;
                    fsm_n  = BUSY;
                end
            end
            BUSY: begin
                for (int k = 0; k < PPC; k++) begin
                    for (int i = 0; i < LANES; i++) begin
                        st_n[i][pidx[k]] = mode_q ? st[i][pidx[k]] : pout[k][i];
                    end
                end
                // The group ending at plane 4 is being written on this edge.
                if (cnt == 3'(LANES - PPC)) begin
                    cnt_n = '0;
                    fsm_n = DONE;
                end else begin
                    cnt_n = cnt + 3'(PPC);
                end
            end
            DONE: begin
                if (out_ready) begin
                    fsm_n = IDLE;
                end
            end
            default: fsm_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            fsm    <= IDLE;
            cnt    <= '0;
            mode_q <= 1'b0;
            st     <= '0;
        end else begin
            fsm    <= fsm_n;
            cnt    <= cnt_n;
            mode_q <= mode_n;
            st     <= st_n;
        end
    end

    assign in_ready  = (fsm == IDLE);
    assign out_valid = (fsm == DONE);
    assign busy      = (fsm == BUSY);
    assign Ab        = st;

endmodule

// File: tb/tb_keccak_chi_seq.sv
// Bench for keccak_chi_seq: PPC=1 and PPC=5 instances driven side by side and
// compared against a lane-level chi reference.
module tb_keccak_chi_seq;

    localparam int W  = keccak_pkg::W_DEFAULT;
    localparam int SW = 25 * W;

    typedef logic [4:0][4:0][W-1:0] st_t;

    logic clk = 1'b0;
    logic reset;
    logic in_valid;
    logic mode;
    st_t  A;
    logic in_ready1, out_valid1, out_ready1, busy1;
    logic in_ready5, out_valid5, out_ready5, busy5;
    st_t  Ab1, Ab5;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    keccak_chi_seq #(.W(W), .PPC(1)) dut1 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready1),
        .mode(mode), .A(A), .out_valid(out_valid1), .out_ready(out_ready1),
        .Ab(Ab1), .busy(busy1)
    );

    keccak_chi_seq #(.W(W), .PPC(5)) dut5 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready5),
        .mode(mode), .A(A), .out_valid(out_valid5), .out_ready(out_ready5),
        .Ab(Ab5), .busy(busy5)
    );

    task automatic check(input string tag, input logic [SW-1:0] got, input logic [SW-1:0] exp);
        int lane;
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            lane = 0;
            for (int b = SW - 1; b >= 0; b--) begin
                if (got[b] !== exp[b]) lane = b / W;
            end
            $display("FAIL %s lane%0d got=%h exp=%h", tag, lane, got[lane*W +: W], exp[lane*W +: W]);
        end
    endtask

    function automatic st_t ref_chi(input st_t a, input logic md);
        logic [W-1:0] l [5][5];
        st_t r;
        for (int i = 0; i < 5; i++)
            for (int j = 0; j < 5; j++)
                l[i][j] = a[i][j];
        for (int i = 0; i < 5; i++)
            for (int j = 0; j < 5; j++)
                r[i][j] = md ? l[i][j] : (l[i][j] ^ (~l[(i + 1) % 5][j] & l[(i + 2) % 5][j]));
        return r;
    endfunction

    function automatic st_t rand_state();
        st_t s;
        logic [63:0] t;
        for (int i = 0; i < 5; i++)
            for (int j = 0; j < 5; j++) begin
                t = {$urandom(), $urandom()};
                s[i][j] = W'(t);
            end
        return s;
    endfunction

    // Accept one state on both instances and wait for both results.
    task automatic txn(input st_t a, input logic md, input st_t exp);
        int lat1, lat5;
        @(negedge clk);
        check("in_ready1_pre", SW'(in_ready1), SW'(1));
        check("in_ready5_pre", SW'(in_ready5), SW'(1));
        A = a;
        mode = md;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        A = rand_state();
        mode = ~md;
        check("busy1", SW'(busy1), SW'(1));
        check("out_valid1_early", SW'(out_valid1), SW'(0));
        lat1 = 0;
        lat5 = 0;
        for (int n = 1; n <= 20; n++) begin
            @(posedge clk);
            #1;
            if (out_valid1 && lat1 == 0) lat1 = n;
            if (out_valid5 && lat5 == 0) lat5 = n;
            if (lat1 != 0 && lat5 != 0) break;
        end
        check("latency1", SW'(lat1), SW'(5));
        check("latency5", SW'(lat5), SW'(1));
        check("Ab1", Ab1, exp);
        check("Ab5", Ab5, exp);
    endtask

    task automatic release_out();
        @(negedge clk);
        out_ready1 = 1'b1;
        out_ready5 = 1'b1;
        @(posedge clk);
        #1;
        check("in_ready1_post", SW'(in_ready1), SW'(1));
        check("in_ready5_post", SW'(in_ready5), SW'(1));
        check("out_valid1_post", SW'(out_valid1), SW'(0));
        out_ready1 = 1'b0;
        out_ready5 = 1'b0;
    endtask

    initial begin
        st_t a, e, hold_exp;
        st_t aq [12];

        reset = 1'b0;
        in_valid = 1'b0;
        mode = 1'b0;
        A = '0;
        out_ready1 = 1'b0;
        out_ready5 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready1", SW'(in_ready1), SW'(1));
        check("rst_out_valid1", SW'(out_valid1), SW'(0));
        check("rst_busy1", SW'(busy1), SW'(0));
        check("rst_Ab1", Ab1, '0);
        check("rst_in_ready5", SW'(in_ready5), SW'(1));
        check("rst_Ab5", Ab5, '0);
        @(negedge clk);
        reset = 1'b1;

        // All-zero state.
        txn('0, 1'b0, '0);
        release_out();

        // Single all-ones lane at i=2, j=0.
        a = '0;
        a[2][0] = '1;
        e = '0;
        e[0][0] = '1;
        e[2][0] = '1;
        txn(a, 1'b0, e);
        release_out();

        for (int v = 0; v < 1000; v++) begin
            a = rand_state();
            txn(a, 1'b0, ref_chi(a, 1'b0));
            release_out();
        end
        for (int v = 0; v < 50; v++) begin
            a = rand_state();
            txn(a, 1'b1, a);
            release_out();
        end

        // Consumer stall: result must hold and new inputs must be ignored.
        a = rand_state();
        hold_exp = ref_chi(a, 1'b0);
        txn(a, 1'b0, hold_exp);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            in_valid = 1'b1;
            A = rand_state();
            mode = 1'b1;
            @(posedge clk);
            #1;
            check("stall_Ab1", Ab1, hold_exp);
            check("stall_Ab5", Ab5, hold_exp);
            check("stall_in_ready1", SW'(in_ready1), SW'(0));
            check("stall_out_valid5", SW'(out_valid5), SW'(1));
        end
        @(negedge clk);
        in_valid = 1'b0;
        release_out();

        // Reset during the third busy cycle.
        @(negedge clk);
        A = rand_state();
        mode = 1'b0;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("abort_in_ready1", SW'(in_ready1), SW'(1));
        check("abort_out_valid1", SW'(out_valid1), SW'(0));
        check("abort_Ab1", Ab1, '0);
        check("abort_in_ready5", SW'(in_ready5), SW'(1));
        check("abort_Ab5", Ab5, '0);
        @(negedge clk);
        reset = 1'b1;
        a = rand_state();
        txn(a, 1'b0, ref_chi(a, 1'b0));
        release_out();

        // Back-to-back on the five-plane instance with the consumer always ready.
        out_ready1 = 1'b1;
        out_ready5 = 1'b1;
        for (int n = 0; n < 12; n++) begin
            @(negedge clk);
            aq[n] = rand_state();
            A = aq[n];
            mode = 1'b0;
            in_valid = 1'b1;
            @(posedge clk);
            #1;
            check("b2b_out_valid5", SW'(out_valid5), SW'((n % 3) == 1));
            if ((n % 3) == 1) check("b2b_Ab5", Ab5, ref_chi(aq[n-1], 1'b0));
        end
        @(negedge clk);
        in_valid = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        check("drain_in_ready1", SW'(in_ready1), SW'(1));
        check("drain_in_ready5", SW'(in_ready5), SW'(1));
        out_ready1 = 1'b0;
        out_ready5 = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/keccak_chi_seq.md
KECCAK_CHI_SEQ -- requirements
Module: keccak_chi_seq

Interface
REQ-001 SHALL have parameter W, default `w from the shared config, meaning lane width in bits.
REQ-002 SHALL have parameter PPC, default 1, meaning planes processed per cycle; legal values are 1 and 5.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: reset is synchronous and active-low.
REQ-005 SHALL have port in_valid, input, 1 bit: the input state is valid.
REQ-006 SHALL have port in_ready, output, 1 bit: the block accepts a new state.
REQ-007 SHALL have port mode, input, 1 bit: 0 = chi, 1 = bypass (identity); sampled at accept.
REQ-008 SHALL have port A, input, 5x5 lanes of W bits: the input state A[i][j].
REQ-009 SHALL have port out_valid, output, 1 bit: Ab holds a finished result.
REQ-010 SHALL have port out_ready, input, 1 bit: the consumer takes the result.
REQ-011 SHALL have port Ab, output, 5x5 lanes of W bits: the result state.
REQ-012 SHALL have port busy, output, 1 bit: high in BUSY.

Function
REQ-013 Chi SHALL be Ab[i][j] = A[i][j] XOR (NOT A[(i+1)%5][j] AND A[(i+2)%5][j]), bitwise over all W bits; plane = fixed j, all five i.
REQ-014 FSM states SHALL be IDLE, BUSY, DONE; in_ready = (state==IDLE); out_valid = (state==DONE).
REQ-015 IDLE: on in_valid&&in_ready, SHALL load A into the internal state register, latch mode, clear plane counter, go to BUSY.
REQ-016 BUSY: each cycle SHALL transform planes cnt..cnt+PPC-1 in place (identity if bypass), then cnt += PPC.
REQ-017 When the final plane (index 4) is written, SHALL go to DONE on that same edge.
REQ-018 Latency SHALL be 5/PPC cycles from the accept edge to the first cycle with out_valid=1 (5 for PPC=1, 1 for PPC=5).
REQ-019 DONE: Ab SHALL be stable while out_valid&&!out_ready; on out_ready SHALL go to IDLE.
REQ-020 in_valid SHALL be ignored outside IDLE; A and mode changes after accept SHALL NOT affect the result.
REQ-021 Ab SHALL drive the internal state register directly; its value outside DONE is don't-care for consumers.
REQ-022 The plane counter SHALL be 3 bits and SHALL NOT exceed 4 at any indexed access.

Reset
REQ-023 reset=0 at a clk edge SHALL force IDLE, counter 0, state register all zeros, latched mode 0.
REQ-024 After reset SHALL hold in_ready=1, out_valid=0, busy=0, Ab all zeros.
REQ-025 Reset mid-BUSY or in DONE SHALL abort and discard the in-flight result, with no out_valid pulse.

Structure
REQ-026 Shared package keccak_pkg SHALL hold the lane count 5, W default, the 5x5 state typedef and the FSM state enum.
REQ-027 SHALL instantiate PPC copies of combinational sub-module keccak_chi_plane (5 lanes in, 5 lanes out, W-parameterised).

Verification
REQ-028 All-zero A, mode 0, PPC=1 -> out_valid exactly 5 cycles after accept, Ab all zeros.
REQ-029 A[2][0]=all-ones, rest 0, mode 0 -> Ab[0][0]=all-ones, Ab[2][0]=all-ones, Ab[1][0]=0, all other lanes 0.
REQ-030 Random A, mode 1 -> Ab==A; random A, mode 0 -> Ab matches the REQ-013 model for 1000 vectors, PPC=1 and PPC=5.
REQ-031 out_ready held 0 for 10 cycles in DONE -> Ab stable, in_ready=0, new in_valid ignored; out_ready=1 -> IDLE next cycle.
REQ-032 reset=0 in BUSY cycle 3 -> next cycle in_ready=1, Ab=0; next accepted state yields a correct result.
REQ-033 PPC=5, back-to-back accept with out_ready tied 1 -> accept, DONE, IDLE repeating; out_valid every third cycle.
